// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I-subset core: sequences fetch/decode/execute/memory/writeback.
// Optional illegal-opcode trap state is built when CTRL_ILLEGAL_TRAP_EN is defined.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] ALUOp,
    output logic       illegal
);

    localparam logic [1:0] ALUOP_S = 2'b00;
    localparam logic [1:0] ALUOP_B = 2'b01;
    localparam logic [1:0] ALUOP_R = 2'b10;
    localparam logic [1:0] ALUOP_I = 2'b11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRAN  = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_LUI,
        S_ERROR
`else
        S_LUI
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
    } ctl_t;

    state_t state;
    state_t state_nx;
    ctl_t   ctl_q;
    ctl_t   ctl_o;
    logic   br_taken;

    // Next-state rule for a given state and latched opcode.
    function automatic state_t next_of(input state_t s, input logic [6:0] o);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (o)
                    OP_LOAD, OP_STORE: n = S_MEMADR;
                    OP_RTYPE:          n = S_EXEC_R;
                    OP_ITYPE:          n = S_EXEC_I;
                    OP_BRAN:           n = S_BRANCH;
                    OP_JAL:            n = S_JAL;
                    OP_JALR:           n = S_JALR;
                    OP_LUI:            n = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           n = S_ERROR;
`else
                    default:           n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  n = (o == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: n = S_MEMWB;
            S_EXEC_R:  n = S_ALUWB;
            S_EXEC_I:  n = S_ALUWB;
            S_JALR:    n = S_JAL;
            S_JAL:     n = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ERROR:   n = S_ERROR;
`endif
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    // Moore control word for each state; BRANCH pc_write and store imm_src are patched later.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_write   = 1'b1;
                c.ir_write   = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
                c.alu_op     = ALUOP_S;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALUOP_S;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_MDR;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_op    = ALUOP_R;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALUOP_I;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_REGA;
                c.alu_op     = ALUOP_B;
                c.result_src = RES_ALUOUT;
            end
            S_JALR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALUOP_S;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_S;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_LUI: begin
                c.imm_src    = IMM_U;
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nx = next_of(state, op);
    end

    // State and control word register; the control word is precomputed for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ctl_q <= ctl_of(S_FETCH);
        end else begin
            state <= state_nx;
            ctl_q <= ctl_of(state_nx);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | (state_nx == S_ERROR);
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Branch condition from ALU flags of rs1 - rs2; overflow deliberately ignored.
    always_comb begin
        br_taken = 1'b0;
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = neg;
            3'b101:  br_taken = ~neg;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        ctl_o = ctl_q;
        if ((state == S_MEMADR) && (op == OP_STORE)) begin
            ctl_o.imm_src = IMM_S;
        end
        if (state == S_BRANCH) begin
            ctl_o.pc_write = br_taken;
        end
        // Reset shows FETCH selects with every write enable suppressed.
        if (rst) begin
            ctl_o           = ctl_of(S_FETCH);
            ctl_o.pc_write  = 1'b0;
            ctl_o.ir_write  = 1'b0;
            ctl_o.mem_write = 1'b0;
            ctl_o.reg_write = 1'b0;
        end
    end

    assign pc_write   = ctl_o.pc_write;
    assign adr_src    = ctl_o.adr_src;
    assign mem_write  = ctl_o.mem_write;
    assign ir_write   = ctl_o.ir_write;
    assign reg_write  = ctl_o.reg_write;
    assign result_src = ctl_o.result_src;
    assign alu_src_a  = ctl_o.alu_src_a;
    assign alu_src_b  = ctl_o.alu_src_b;
    assign imm_src    = ctl_o.imm_src;
    assign ALUOp      = ctl_o.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table, reset/illegal sequences,
// and random instruction streams against a per-instruction-step reference model.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] aluop;
    logic       illegal;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .zero(zero), .neg(neg),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .ALUOp(aluop), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [1:0] alu;
        logic       ill;
    } exp_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       n;
        int         cyc;
        logic       last_pw;
        logic       last_rw;
    } vec_t;

    exp_t act;
    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, aluop, illegal};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk_vec(input string name, input exp_t got, input exp_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, got, want, $time);
        end
    endtask

    // Cycles per instruction class; 0 means the opcode traps forever.
    function automatic int len_of(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b0010011: return 4;
            7'b1100011: return 3;
            7'b1101111: return 4;
            7'b1100111: return 5;
            7'b0110111: return 3;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:    return 0;
`else
            default:    return 2;
`endif
        endcase
    endfunction

    // Expected outputs for cycle st of an instruction with opcode o.
    function automatic exp_t model(input logic [6:0] o, input int st, input logic [2:0] f3,
                                   input logic z, input logic n, input logic r, input logic ill);
        exp_t e;
        logic taken;
        e = '0;
        taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n);
        if (r || st == 0) begin
            e.pw  = !r;
            e.irw = !r;
            e.b   = 2'b10;
            e.res = 2'b10;
            e.ill = r ? ill : 1'b0;
            return e;
        end
        if (st == 1) begin
            e.a = 2'b01; e.b = 2'b01; e.imm = 3'b010;
            return e;
        end
        case (o)
            7'b0000011: begin
                if (st == 2) begin e.a = 2'b10; e.b = 2'b01; end
                else if (st == 3) e.adr = 1'b1;
                else begin e.res = 2'b01; e.rw = 1'b1; end
            end
            7'b0100011: begin
                if (st == 2) begin e.a = 2'b10; e.b = 2'b01; e.imm = 3'b001; end
                else begin e.adr = 1'b1; e.mw = 1'b1; end
            end
            7'b0110011: begin
                if (st == 2) begin e.a = 2'b10; e.alu = 2'b10; end
                else e.rw = 1'b1;
            end
            7'b0010011: begin
                if (st == 2) begin e.a = 2'b10; e.b = 2'b01; e.alu = 2'b11; end
                else e.rw = 1'b1;
            end
            7'b1100011: begin
                e.a = 2'b10; e.alu = 2'b01; e.pw = taken;
            end
            7'b1100111: begin
                if (st == 2) begin e.a = 2'b10; e.b = 2'b01; end
                else if (st == 3) begin e.a = 2'b01; e.b = 2'b10; e.pw = 1'b1; end
                else e.rw = 1'b1;
            end
            7'b1101111: begin
                if (st == 2) begin e.a = 2'b01; e.b = 2'b10; e.pw = 1'b1; end
                else e.rw = 1'b1;
            end
            7'b0110111: begin
                e.imm = 3'b100; e.res = 2'b11; e.rw = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    vec_t       tbl[$];
    logic [6:0] ops[10];

    initial begin
        int         step;
        logic       trapped;
        logic [6:0] cur_op;

        rst = 1'b1; op = 7'b0110011; func3 = 3'd0; zero = 1'b0; neg = 1'b0;

        tbl.push_back('{"rtype",   7'b0110011, 3'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1});
        tbl.push_back('{"load",    7'b0000011, 3'd0, 1'b0, 1'b0, 5, 1'b0, 1'b1});
        tbl.push_back('{"store",   7'b0100011, 3'd0, 1'b0, 1'b0, 4, 1'b0, 1'b0});
        tbl.push_back('{"itype",   7'b0010011, 3'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1});
        tbl.push_back('{"beq_t",   7'b1100011, 3'd0, 1'b1, 1'b0, 3, 1'b1, 1'b0});
        tbl.push_back('{"bne_nt",  7'b1100011, 3'd1, 1'b1, 1'b0, 3, 1'b0, 1'b0});
        tbl.push_back('{"bne_t",   7'b1100011, 3'd1, 1'b0, 1'b0, 3, 1'b1, 1'b0});
        tbl.push_back('{"blt_t",   7'b1100011, 3'd4, 1'b0, 1'b1, 3, 1'b1, 1'b0});
        tbl.push_back('{"bge_t",   7'b1100011, 3'd5, 1'b0, 1'b0, 3, 1'b1, 1'b0});
        tbl.push_back('{"bf3_010", 7'b1100011, 3'd2, 1'b1, 1'b1, 3, 1'b0, 1'b0});
        tbl.push_back('{"jal",     7'b1101111, 3'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1});
        tbl.push_back('{"jalr",    7'b1100111, 3'd0, 1'b0, 1'b0, 5, 1'b0, 1'b1});
        tbl.push_back('{"lui",     7'b0110111, 3'd0, 1'b0, 1'b0, 3, 1'b0, 1'b1});
`ifndef CTRL_ILLEGAL_TRAP_EN
        tbl.push_back('{"nop_bad", 7'b1111111, 3'd0, 1'b0, 1'b0, 2, 1'b0, 1'b0});
`endif

        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
        ops[8] = 7'b1111111; ops[9] = 7'b0000000;

        // Reset state: FETCH selects, every enable low.
        tick();
        chk_vec("reset_state", act, model(7'b0, 0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        chk_vec("reset_held", act, model(7'b0, 0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        rst = 1'b0;
        #1;
        chk_vec("first_fetch", act, model(7'b0, 0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Table: cycle count and final-cycle write enables per instruction.
        foreach (tbl[i]) begin
            int   n;
            logic lpw;
            logic lrw;
            op = tbl[i].op; func3 = tbl[i].f3; zero = tbl[i].z; neg = tbl[i].n;
            #1;
            n = 0; lpw = 1'b0; lrw = 1'b0;
            do begin
                lpw = pc_write;
                lrw = reg_write;
                tick();
                n++;
            end while (!ir_write && n < 20);
            chk({tbl[i].name, "_cycles"}, 32'(n), 32'(tbl[i].cyc));
            chk({tbl[i].name, "_pc_write"}, 32'(lpw), 32'(tbl[i].last_pw));
            chk({tbl[i].name, "_reg_write"}, 32'(lrw), 32'(tbl[i].last_rw));
            chk({tbl[i].name, "_illegal"}, 32'(illegal), 32'd0);
        end

        // Reset during MEMWRITE abandons the store.
        do_reset();
        op = 7'b0100011;
        tick(); tick(); tick();
        chk("memwrite_before_rst", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_in_memwrite_enables", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        chk("rst_in_memwrite_selects", 32'({alu_src_b, result_src}), 32'b1010);
        tick();
        chk("rst_held_enables", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_fetch", 32'({ir_write, pc_write, mem_write}), 32'b110);

        // Unknown opcode.
        op = 7'b1111111;
        tick(); tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_enables", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("trap_cleared", 32'(illegal), 32'd0);
        rst = 1'b0;
        #1;
`else
        chk("bad_op_nop_fetch", 32'(ir_write), 32'd1);
        chk("bad_op_no_illegal", 32'(illegal), 32'd0);
`endif

        // Random instruction stream with random flags and occasional reset.
        do_reset();
        step = 0; trapped = 1'b0; cur_op = 7'b0110011;
        for (int c = 0; c < 3000; c++) begin
            logic r;
            int   len;
            r = ($urandom_range(0, 24) == 0);
            if (step == 0 && !r) cur_op = ops[$urandom_range(0, 9)];
            op = cur_op;
            func3 = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            neg = 1'($urandom_range(0, 1));
            rst = r;
            #1;
            chk_vec("random", act, model(cur_op, step, func3, zero, neg, r, trapped));
            tick();
            if (r) begin
                step = 0;
                trapped = 1'b0;
            end else begin
                len = len_of(cur_op);
                if (len == 0) begin
                    if (step < 2) step++;
                    trapped = (step >= 2);
                end else begin
                    step = (step + 1) % len;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
